// File: rtl/collatz_sequencer.sv
// Collatz orbit sequencer: iterates n to 1 one step per clock, reporting orbit length and path record.
// Optional COLLATZ_SHORTCUT_EN folds each odd step with the following halving into one cycle.
module collatz_sequencer #(
  parameter int BITS     = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [BITS-1:0]     start_value,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CNT_BITS-1:0] orbit_len,
  output logic [BITS:0]       path_record
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [BITS+2:0]     ONE_EXT = (BITS+3)'(1);

  state_t          state;
  logic [BITS:0]   n;
  logic [BITS+2:0] triple;
  logic            overflow;
  logic [BITS:0]   triple_lo;
  logic [BITS:0]   odd_next;
  logic [CNT_BITS-1:0] odd_len;
  logic            odd_sat;

  // 3n+1 is formed two bits wider than n so any carry out of BITS+1 bits is visible.
  assign triple    = {2'b00, n} + {1'b0, n, 1'b0} + ONE_EXT;
  assign overflow  = |triple[BITS+2:BITS+1];
  assign triple_lo = triple[BITS:0];

`ifdef COLLATZ_SHORTCUT_EN
  assign odd_next = triple[BITS+1:1];
  assign odd_len  = orbit_len + CNT_BITS'(2);
  assign odd_sat  = (orbit_len >= CNT_MAX - CNT_BITS'(1));
`else
  assign odd_next = triple_lo;
  assign odd_len  = orbit_len + CNT_BITS'(1);
  assign odd_sat  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      n           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      orbit_len   <= '0;
      path_record <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            n           <= {1'b0, start_value};
            path_record <= {1'b0, start_value};
            orbit_len   <= '0;
            error       <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b1;
          end else if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (n == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b1;
          end else if (n == (BITS+1)'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b0;
          end else if (orbit_len == CNT_MAX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b1;
          end else if (!n[0]) begin
            n         <= n >> 1;
            orbit_len <= orbit_len + CNT_BITS'(1);
          end else if (overflow || odd_sat) begin
            // Results hold at their last good values when the odd step cannot proceed.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= 1'b1;
          end else begin
            n         <= odd_next;
            orbit_len <= odd_len;
            if (triple_lo > path_record) begin
              path_record <= triple_lo;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collatz_sequencer.sv
// Directed testbench for collatz_sequencer: default, 4-bit counter and 8-bit datapath instances
// share control inputs and are checked against hand-computed orbits.
module tb_collatz_sequencer;

`ifdef COLLATZ_SHORTCUT_EN
  localparam int BUSY6 = 7;
`else
  localparam int BUSY6 = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] start_value;

  logic        busy0, done0, error0;
  logic [15:0] orbit0;
  logic [32:0] record0;

  logic        busy_c4, done_c4, error_c4;
  logic [3:0]  orbit_c4;
  logic [32:0] record_c4;

  logic        busy_b8, done_b8, error_b8;
  logic [15:0] orbit_b8;
  logic [8:0]  record_b8;

  int          sel;
  logic        sel_busy;
  int          assert_count = 0;
  int          fail_count   = 0;
  int          cycles;

  always #5 clk = ~clk;

  collatz_sequencer #(.BITS(32), .CNT_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .start_value(start_value),
    .busy(busy0), .done(done0), .error(error0), .orbit_len(orbit0), .path_record(record0)
  );

  collatz_sequencer #(.BITS(32), .CNT_BITS(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .start_value(start_value),
    .busy(busy_c4), .done(done_c4), .error(error_c4), .orbit_len(orbit_c4), .path_record(record_c4)
  );

  collatz_sequencer #(.BITS(8), .CNT_BITS(16)) dut_b8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .start_value(start_value[7:0]),
    .busy(busy_b8), .done(done_b8), .error(error_b8), .orbit_len(orbit_b8), .path_record(record_b8)
  );

  always_comb begin
    sel_busy = busy0;
    case (sel)
      1: sel_busy = busy_c4;
      2: sel_busy = busy_b8;
      default: sel_busy = busy0;
    endcase
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    assert_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Pulses start for one edge; returns at the following negedge, the first busy cycle.
  task automatic applyStimulus(input logic [31:0] value);
    @(negedge clk);
    start_value = value;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
  endtask

  task automatic waitDone(output int count);
    count = 0;
    while (sel_busy && count < 2000) begin
      count++;
      @(negedge clk);
    end
    if (count >= 2000) checkOutput("timeout_busy", 1, 0);
  endtask

  task automatic waitAllIdle();
    int guard;
    guard = 0;
    while ((busy0 || busy_c4 || busy_b8) && guard < 2000) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 2000) checkOutput("timeout_idle", 1, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    start_value = '0;
    sel         = 0;
    #1;
    checkOutput("reset_busy", busy0, 0);
    checkOutput("reset_done", done0, 0);
    checkOutput("reset_error", error0, 0);
    checkOutput("reset_orbit", orbit0, 0);
    checkOutput("reset_record", record0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'd1);
    waitDone(cycles);
    checkOutput("n1_busy_cycles", cycles, 1);
    checkOutput("n1_done", done0, 1);
    checkOutput("n1_orbit", orbit0, 0);
    checkOutput("n1_record", record0, 1);
    checkOutput("n1_error", error0, 0);
    waitAllIdle();

    applyStimulus(32'd6);
    waitDone(cycles);
    checkOutput("n6_busy_cycles", cycles, BUSY6);
    checkOutput("n6_done", done0, 1);
    checkOutput("n6_orbit", orbit0, 8);
    checkOutput("n6_record", record0, 16);
    checkOutput("n6_error", error0, 0);
    waitAllIdle();

    applyStimulus(32'd27);
    waitDone(cycles);
    waitAllIdle();
    checkOutput("n27_orbit", orbit0, 111);
    checkOutput("n27_record", record0, 9232);
    checkOutput("n27_error", error0, 0);
    checkOutput("c4_done", done_c4, 1);
    checkOutput("c4_error", error_c4, 1);
    checkOutput("c4_orbit", orbit_c4, 15);
    checkOutput("c4_record", record_c4, 484);

    // Abort outside RUN only drops done; results stay readable.
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort_done", done0, 0);
    checkOutput("idle_abort_orbit", orbit0, 111);

    sel = 2;
    applyStimulus(32'd255);
    waitDone(cycles);
    checkOutput("b8_busy_cycles", cycles, 1);
    checkOutput("b8_error", error_b8, 1);
    checkOutput("b8_done", done_b8, 1);
    checkOutput("b8_orbit", orbit_b8, 0);
    checkOutput("b8_record", record_b8, 255);
    sel = 0;
    waitAllIdle();

    applyStimulus(32'd0);
    waitDone(cycles);
    checkOutput("n0_busy_cycles", cycles, 1);
    checkOutput("n0_done", done0, 1);
    checkOutput("n0_error", error0, 1);
    checkOutput("n0_orbit", orbit0, 0);
    waitAllIdle();

    applyStimulus(32'd27);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy0, 0);
    checkOutput("abort_done", done0, 0);
    checkOutput("abort_orbit", orbit0, 9);
    checkOutput("abort_record", record0, 142);
    waitAllIdle();

    applyStimulus(32'd27);
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", busy0, 0);
    checkOutput("midreset_done", done0, 0);
    checkOutput("midreset_error", error0, 0);
    checkOutput("midreset_orbit", orbit0, 0);
    checkOutput("midreset_record", record0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(32'd6);
    repeat (2) @(negedge clk);
    start_value = 32'd27;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    waitDone(cycles);
    checkOutput("restart_busy_cycles", cycles + 3, BUSY6);
    checkOutput("restart_orbit", orbit0, 8);
    checkOutput("restart_record", record0, 16);
    checkOutput("restart_error", error0, 0);
    waitAllIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
